hazard_stall_ctrl: RTL and testbench

//  Pipeline hazard/sequencing controller for the ID/EX (Decode->Execute) register and the IF/ID stage.

---
 rtl/hazard_stall_ctrl.sv | 173 +++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//   Hazard and sequencing controller for the IF/ID and ID/EX pipeline registers.
//   - Load-use hazard: stalls PC and IF/ID for one cycle and injects one bubble
//     into ID/EX.
//   - Multi-cycle ALU op: after the op's first EX cycle, the pipe is held for
//     MULT_LAT-1 further cycles (PC, IF/ID and ID/EX held, bubbles into EX/MEM).
//   - Taken branch in Decode: flushes IF/ID, unless a load-use stall wins.
//   - EX-stage operand forwarding selects (MEM result beats WB result).
//   - Saturating count of cycles with stall_f_o asserted.
//
// Parameters
//   MULT_LAT  total EX cycles of a multi-cycle op (>= 2)
//   CNT_W     width of stall_count_o
//
// Ports
//   clk_i            clock, all state updates on rising edge
//   rst_i            synchronous active-high reset
//   rs_d_i, rt_d_i   source registers of the instruction in Decode
//   rs_e_i, rt_e_i   source registers of the instruction in Execute
//   mem_read_e_i     instruction in Execute is a load
//   write_reg_e_i    destination register of the instruction in Execute
//   mult_start_e_i   one-cycle pulse: multi-cycle op entered Execute
//   branch_taken_d_i branch in Decode resolved taken
//   reg_write_m_i    MEM-stage instruction writes a register
//   write_reg_m_i    MEM-stage destination register
//   reg_write_w_i    WB-stage instruction writes a register
//   write_reg_w_i    WB-stage destination register
//   stall_f_o        hold PC
//   stall_d_o        hold IF/ID register
//   stall_e_o        hold ID/EX register
//   flush_d_o        clear IF/ID register
//   flush_e_o        load bubble into ID/EX
//   flush_m_o        load bubble into EX/MEM
//   forward_a_e_o    ALU operand A select: 00 regfile, 01 WB, 10 MEM
//   forward_b_e_o    ALU operand B select, same encoding
//   busy_o           multi-cycle hold in progress
//   stall_count_o    cycles with stall_f_o=1 since reset, saturating
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
  parameter int MULT_LAT = 4,
  parameter int CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       rs_d_i,
  input  logic [4:0]       rt_d_i,
  input  logic [4:0]       rs_e_i,
  input  logic [4:0]       rt_e_i,
  input  logic             mem_read_e_i,
  input  logic [4:0]       write_reg_e_i,
  input  logic             mult_start_e_i,
  input  logic             branch_taken_d_i,
  input  logic             reg_write_m_i,
  input  logic [4:0]       write_reg_m_i,
  input  logic             reg_write_w_i,
  input  logic [4:0]       write_reg_w_i,
  output logic             stall_f_o,
  output logic             stall_d_o,
  output logic             stall_e_o,
  output logic             flush_d_o,
  output logic             flush_e_o,
  output logic             flush_m_o,
  output logic [1:0]       forward_a_e_o,
  output logic [1:0]       forward_b_e_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] stall_count_o
);

  localparam int CNT_LW = $clog2(MULT_LAT) + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_LW-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]   stall_count_q, stall_count_d;
  logic               load_use;

  // Operand select for one EX source register; MEM is the younger result so
  // it takes priority, and r0 is hardwired zero so it is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    if (reg_write_m_i && (write_reg_m_i != 5'd0) && (write_reg_m_i == src)) begin
      sel = 2'b10;
    end else if (reg_write_w_i && (write_reg_w_i != 5'd0) && (write_reg_w_i == src)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  assign load_use = mem_read_e_i && (write_reg_e_i != 5'd0) &&
                    ((write_reg_e_i == rs_d_i) || (write_reg_e_i == rt_d_i));

  assign forward_a_e_o = fwd_sel(rs_e_i);
  assign forward_b_e_o = fwd_sel(rt_e_i);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case/if tree leaves a value unassigned and no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_f_o = 1'b0;
    stall_d_o = 1'b0;
    stall_e_o = 1'b0;
    flush_d_o = 1'b0;
    flush_e_o = 1'b0;
    flush_m_o = 1'b0;
    busy_o    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // The op spends its first cycle in EX unstalled; the hold begins next.
        if (mult_start_e_i) begin
          state_d = ST_MUL;
          cnt_d   = CNT_LW'(MULT_LAT - 1);
        end
        if (load_use) begin
          stall_f_o = 1'b1;
          stall_d_o = 1'b1;
          flush_e_o = 1'b1;
        end else if (branch_taken_d_i) begin
          flush_d_o = 1'b1;
        end
      end
      ST_MUL: begin
        // Hazards seen in Decode are ignored here; the held instruction is
        // re-evaluated once the hold releases.
        stall_f_o = 1'b1;
        stall_d_o = 1'b1;
        stall_e_o = 1'b1;
        flush_m_o = 1'b1;
        busy_o    = 1'b1;
        cnt_d     = cnt_q - CNT_LW'(1);
        if (cnt_q <= CNT_LW'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_f_o && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  assign stall_count_o = stall_count_q;

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//   Scoreboard bench for hazard_stall_ctrl (MULT_LAT=4, CNT_W=3). The driver
//   applies inputs each cycle, predicts the outputs from a reference model
//   that tracks "hold cycles remaining" and a stall total, and pushes the
//   prediction into a queue. A monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

  localparam int MULT_LAT = 4;
  localparam int CNT_W    = 3;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [4:0]       rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
  logic             mem_read_e, mult_start_e, branch_taken_d, reg_write_m, reg_write_w;
  logic             stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, busy;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_count;

  hazard_stall_ctrl #(.MULT_LAT(MULT_LAT), .CNT_W(CNT_W)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .rs_d_i          (rs_d),
    .rt_d_i          (rt_d),
    .rs_e_i          (rs_e),
    .rt_e_i          (rt_e),
    .mem_read_e_i    (mem_read_e),
    .write_reg_e_i   (wr_e),
    .mult_start_e_i  (mult_start_e),
    .branch_taken_d_i(branch_taken_d),
    .reg_write_m_i   (reg_write_m),
    .write_reg_m_i   (wr_m),
    .reg_write_w_i   (reg_write_w),
    .write_reg_w_i   (wr_w),
    .stall_f_o       (stall_f),
    .stall_d_o       (stall_d),
    .stall_e_o       (stall_e),
    .flush_d_o       (flush_d),
    .flush_e_o       (flush_e),
    .flush_m_o       (flush_m),
    .forward_a_e_o   (fwd_a),
    .forward_b_e_o   (fwd_b),
    .busy_o          (busy),
    .stall_count_o   (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string tag;
    bit    sf, sd, se, fd, fe, fm, bz;
    int    fa, fb, cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: cycles of multi-cycle hold still owed, and stalls seen.
  int   hold_left  = 0;
  int   stall_tot  = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic int model_fwd(input int src);
    if (reg_write_m && wr_m != 0 && int'(wr_m) == src) return 2;
    if (reg_write_w && wr_w != 0 && int'(wr_w) == src) return 1;
    return 0;
  endfunction

  // Predict this cycle's outputs from the current inputs, queue them, then
  // advance the model to what the next clock edge will leave behind.
  task automatic step(input string tag);
    exp_t e;
    bit   lu;
    e.tag = tag;
    lu = mem_read_e && wr_e != 0 && (wr_e == rs_d || wr_e == rt_d);
    e.bz = (hold_left > 0);
    e.se = e.bz;
    e.fm = e.bz;
    e.sf = e.bz || lu;
    e.sd = e.sf;
    e.fe = !e.bz && lu;
    e.fd = !e.bz && !lu && branch_taken_d;
    e.fa = model_fwd(int'(rs_e));
    e.fb = model_fwd(int'(rt_e));
    e.cnt = stall_tot;
    exp_q.push_back(e);

    if (rst) begin
      hold_left = 0;
      stall_tot = 0;
    end else begin
      if (e.sf && stall_tot < CNT_MAX) stall_tot++;
      if (hold_left > 0)     hold_left--;
      else if (mult_start_e) hold_left = MULT_LAT - 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0; wr_e = 0; wr_m = 0; wr_w = 0;
    mem_read_e = 0; mult_start_e = 0; branch_taken_d = 0;
    reg_write_m = 0; reg_write_w = 0; rst = 0;
  endtask

  // Monitor: every cycle the DUT presents a full output vector.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.tag, ".stall_f"}, int'(stall_f), int'(e.sf));
        check({e.tag, ".stall_d"}, int'(stall_d), int'(e.sd));
        check({e.tag, ".stall_e"}, int'(stall_e), int'(e.se));
        check({e.tag, ".flush_d"}, int'(flush_d), int'(e.fd));
        check({e.tag, ".flush_e"}, int'(flush_e), int'(e.fe));
        check({e.tag, ".flush_m"}, int'(flush_m), int'(e.fm));
        check({e.tag, ".busy"},    int'(busy),    int'(e.bz));
        check({e.tag, ".fwd_a"},   int'(fwd_a),   e.fa);
        check({e.tag, ".fwd_b"},   int'(fwd_b),   e.fb);
        check({e.tag, ".count"},   int'(stall_count), e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    zero_inputs();
    // Bring DUT state out of X before any prediction is made.
    rst = 1;
    @(posedge clk);
    #1;

    // Reset with all inputs at 0.
    step("reset0");
    step("reset1");
    rst = 0;
    step("idle");

    // Load-use on rs, then released, then a load to r0 (never a hazard).
    mem_read_e = 1; wr_e = 8; rs_d = 8;
    step("loaduse");
    zero_inputs();
    step("loaduse_after");
    mem_read_e = 1; wr_e = 0; rs_d = 0;
    step("load_r0");
    zero_inputs();

    // Multi-cycle op with taken branches during the hold.
    mult_start_e = 1;
    step("mult_start");
    mult_start_e = 0; branch_taken_d = 1;
    for (int i = 0; i < MULT_LAT - 1; i++) step("mult_hold");
    branch_taken_d = 0;
    step("mult_release");

    // Forwarding priority and r0 exclusion.
    rs_e = 5; rt_e = 5; wr_m = 5; wr_w = 5; reg_write_m = 1; reg_write_w = 1;
    step("fwd_mem");
    reg_write_m = 0;
    step("fwd_wb");
    rs_e = 0; rt_e = 0; wr_m = 0; wr_w = 0; reg_write_m = 1;
    step("fwd_r0");
    zero_inputs();

    // Reset in the second hold cycle.
    mult_start_e = 1;
    step("mult2_start");
    mult_start_e = 0;
    step("mult2_hold1");
    rst = 1;
    step("mult2_rst");
    rst = 0;
    step("after_rst");

    // Ten back-to-back load-use stalls saturate the 3-bit counter; the
    // simultaneous taken branch must not flush.
    mem_read_e = 1; wr_e = 3; rt_d = 3; branch_taken_d = 1;
    for (int i = 0; i < 10; i++) step("sat");
    zero_inputs();
    step("sat_after");
    branch_taken_d = 1;
    step("branch_alone");
    zero_inputs();

    // Randomized traffic with small register numbers to force matches.
    for (int i = 0; i < 400; i++) begin
      rs_d = 5'($urandom_range(0, 3));
      rt_d = 5'($urandom_range(0, 3));
      rs_e = 5'($urandom_range(0, 3));
      rt_e = 5'($urandom_range(0, 3));
      wr_e = 5'($urandom_range(0, 3));
      wr_m = 5'($urandom_range(0, 3));
      wr_w = 5'($urandom_range(0, 3));
      mem_read_e     = ($urandom_range(0, 2) == 0);
      mult_start_e   = ($urandom_range(0, 7) == 0);
      branch_taken_d = ($urandom_range(0, 3) == 0);
      reg_write_m    = $urandom_range(0, 1) == 1;
      reg_write_w    = $urandom_range(0, 1) == 1;
      rst            = ($urandom_range(0, 59) == 0);
      step("rand");
    end
    zero_inputs();

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
